nibble_serial_adder_ctrl: RTL and testbench



---
 rtl/nibble_serial_adder_ctrl_if.sv | 58 +++++
 rtl/nibble_serial_adder_ctrl.sv | 142 ++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_ctrl_if.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl_if
//
// Purpose: groups the start handshake, operand bus and result bus of the
// nibble-serial adder controller so requester and controller connect through
// one bundle.
//
// Signals:
//   start_valid  requester -> ctrl  operation present on a_in/b_in/cin
//   start_ready  ctrl -> requester  controller can accept (IDLE only)
//   a_in, b_in   requester -> ctrl  WIDTH-bit operands, sampled on accept
//   cin          requester -> ctrl  carry into bit 0, sampled on accept
//   busy         ctrl -> requester  operation in progress (RUN or DONE)
//   sum_out      ctrl -> consumer   registered result, held until next done
//   cout         ctrl -> consumer   registered carry out, held with sum_out
//   done         ctrl -> consumer   one-cycle pulse: result just updated
//
// Modports:
//   master  requester side (drives handshake and operands)
//   slave   controller side (drives ready, busy and results)
// ---------------------------------------------------------------------------
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start_valid;
    logic             start_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic             busy;
    logic [WIDTH-1:0] sum_out;
    logic             cout;
    logic             done;

    modport master (
        output start_valid,
        output a_in,
        output b_in,
        output cin,
        input  start_ready,
        input  busy,
        input  sum_out,
        input  cout,
        input  done
    );

    modport slave (
        input  start_valid,
        input  a_in,
        input  b_in,
        input  cin,
        output start_ready,
        output busy,
        output sum_out,
        output cout,
        output done
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// nibble_serial_adder_ctrl
//
// Purpose: adds two WIDTH-bit operands four bits per clock through a single
// shared 4-bit ripple-carry slice (four chained full-adder cells). A
// registered carry links successive nibbles, trading latency for area.
// The sum becomes visible only when the whole operation has finished.
//
// Parameters:
//   WIDTH  operand/result width; must be a multiple of 4 and >= 4
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  slave side of nibble_serial_adder_ctrl_if (handshake, operands,
//        busy, sum_out, cout, done)
// ---------------------------------------------------------------------------
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    nibble_serial_adder_ctrl_if.slave    bus
);

    localparam int NIBBLES = WIDTH / 4;
    // One bit minimum so the single-nibble build still has a legal counter.
    localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic             carry_q;
    logic [WIDTH-1:0] aOp_q;
    logic [WIDTH-1:0] bOp_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             done_q;
    logic             busy_q;
    logic             ready_q;

    logic [3:0]       aNib_d;
    logic [3:0]       bNib_d;
    logic [3:0]       sliceSum_d;
    logic             sliceCarry_d;
    logic [WIDTH-1:0] accMerged_d;

    // Shared 4-bit ripple-carry slice: picks the current nibble of each
    // operand and chains four full-adder cells starting from the carry
    // register. The merged accumulator lets the final edge publish the
    // complete sum without waiting an extra cycle for the last nibble.
    always_comb begin
        logic [4:0] chain;
        aNib_d     = aOp_q[{idx_q, 2'b00} +: 4];
        bNib_d     = bOp_q[{idx_q, 2'b00} +: 4];
        chain      = 5'b0;
        chain[0]   = carry_q;
        sliceSum_d = 4'b0;
        for (int i = 0; i < 4; i++) begin
            sliceSum_d[i] = aNib_d[i] ^ bNib_d[i] ^ chain[i];
            chain[i+1]    = (aNib_d[i] & bNib_d[i]) |
                            (chain[i] & (aNib_d[i] ^ bNib_d[i]));
        end
        sliceCarry_d = chain[4];
        accMerged_d  = acc_q;
        accMerged_d[{idx_q, 2'b00} +: 4] = sliceSum_d;
    end

    // Control FSM with registered outputs. Ready, busy and done are updated
    // together with the state so each output is a pure function of the
    // state register; the result registers only move on the final RUN edge
    // so partial sums never leak out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            aOp_q   <= '0;
            bOp_q   <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start_valid && ready_q) begin
                        aOp_q   <= bus.a_in;
                        bOp_q   <= bus.b_in;
                        carry_q <= bus.cin;
                        idx_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q   <= accMerged_d;
                    carry_q <= sliceCarry_d;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        sum_q   <= accMerged_d;
                        cout_q  <= sliceCarry_d;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    // No accept from DONE: the requester sees ready only
                    // once the controller is back in IDLE.
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = ready_q;
    assign bus.busy        = busy_q;
    assign bus.sum_out     = sum_q;
    assign bus.cout        = cout_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
//
// Purpose: directed self-checking bench for nibble_serial_adder_ctrl. Builds
// the controller at WIDTH=16, 8 and 4; a select variable routes the shared
// stimulus to one build and its outputs to the checker.
// ---------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

    logic        clk;
    logic        rst;
    int          sel;
    logic        tbValid;
    logic [15:0] tbA;
    logic [15:0] tbB;
    logic        tbCin;

    int          errors;
    int          checks;

    logic [15:0] obsSum;
    logic        obsCout;
    logic        obsDone;
    logic        obsBusy;
    logic        obsReady;

    nibble_serial_adder_ctrl_if #(.WIDTH(16)) if16 ();
    nibble_serial_adder_ctrl_if #(.WIDTH(8))  if8  ();
    nibble_serial_adder_ctrl_if #(.WIDTH(4))  if4  ();

    nibble_serial_adder_ctrl #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(if16));
    nibble_serial_adder_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(if8));
    nibble_serial_adder_ctrl #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(if4));

    // Only the selected build ever sees start_valid.
    assign if16.start_valid = tbValid && (sel == 0);
    assign if16.a_in        = tbA;
    assign if16.b_in        = tbB;
    assign if16.cin         = tbCin;
    assign if8.start_valid  = tbValid && (sel == 1);
    assign if8.a_in         = tbA[7:0];
    assign if8.b_in         = tbB[7:0];
    assign if8.cin          = tbCin;
    assign if4.start_valid  = tbValid && (sel == 2);
    assign if4.a_in         = tbA[3:0];
    assign if4.b_in         = tbB[3:0];
    assign if4.cin          = tbCin;

    // Route the selected build's outputs to the checker.
    always_comb begin
        obsSum   = if16.sum_out;
        obsCout  = if16.cout;
        obsDone  = if16.done;
        obsBusy  = if16.busy;
        obsReady = if16.start_ready;
        if (sel == 1) begin
            obsSum   = {8'h00, if8.sum_out};
            obsCout  = if8.cout;
            obsDone  = if8.done;
            obsBusy  = if8.busy;
            obsReady = if8.start_ready;
        end else if (sel == 2) begin
            obsSum   = {12'h000, if4.sum_out};
            obsCout  = if4.cout;
            obsDone  = if4.done;
            obsBusy  = if4.busy;
            obsReady = if4.start_ready;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge in IDLE: presents the operation, lets the accept
    // edge pass and returns at the first negedge after it.
    task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b,
                                 input logic c, input bit keepValid);
        tbA     = a;
        tbB     = b;
        tbCin   = c;
        tbValid = 1'b1;
        checkOutput({tag, " ready before accept"}, obsReady, 1);
        @(posedge clk);
        @(negedge clk);
        if (!keepValid) tbValid = 1'b0;
    endtask

    // Starts at the first negedge after accept; follows the operation to the
    // done pulse and into the following IDLE cycle.
    task automatic waitDone(input string tag, input logic [15:0] expSum, input logic expCout,
                            input logic [15:0] prevSum, input logic prevCout, input int expEdges);
        int edges;
        edges = 0;
        while (obsDone !== 1'b1 && edges < 40) begin
            checkOutput({tag, " busy in run"},  obsBusy,  1);
            checkOutput({tag, " ready in run"}, obsReady, 0);
            checkOutput({tag, " sum held"},     obsSum,   prevSum);
            checkOutput({tag, " cout held"},    obsCout,  prevCout);
            @(negedge clk);
            edges++;
        end
        checkOutput({tag, " latency"},       edges,    expEdges);
        checkOutput({tag, " done pulse"},    obsDone,  1);
        checkOutput({tag, " busy in done"},  obsBusy,  1);
        checkOutput({tag, " ready in done"}, obsReady, 0);
        checkOutput({tag, " sum"},           obsSum,   expSum);
        checkOutput({tag, " cout"},          obsCout,  expCout);
        @(negedge clk);
        checkOutput({tag, " done width"},    obsDone,  0);
        checkOutput({tag, " busy idle"},     obsBusy,  0);
        checkOutput({tag, " ready idle"},    obsReady, 1);
        checkOutput({tag, " sum kept"},      obsSum,   expSum);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        sel     = 0;
        rst     = 1'b1;
        tbValid = 1'b1;
        tbA     = 16'h7777;
        tbB     = 16'h1111;
        tbCin   = 1'b1;

        // Reset with a pending request that must be ignored.
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset sum",   obsSum,   0);
        checkOutput("reset cout",  obsCout,  0);
        checkOutput("reset done",  obsDone,  0);
        checkOutput("reset busy",  obsBusy,  0);
        checkOutput("reset ready", obsReady, 1);
        rst     = 1'b0;
        tbValid = 1'b0;
        @(negedge clk);
        checkOutput("post reset busy",  obsBusy,  0);
        checkOutput("post reset ready", obsReady, 1);

        $display("[TB] basic add 0x1234+0x4321");
        applyStimulus("add1", 16'h1234, 16'h4321, 1'b0, 1'b0);
        waitDone("add1", 16'h5555, 1'b0, 16'h0000, 1'b0, 4);

        $display("[TB] result held during run");
        applyStimulus("hold", 16'h0001, 16'h0001, 1'b0, 1'b0);
        waitDone("hold", 16'h0002, 1'b0, 16'h5555, 1'b0, 4);

        $display("[TB] carry ripple across nibbles");
        applyStimulus("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        waitDone("ripple", 16'h0000, 1'b1, 16'h0002, 1'b0, 4);

        applyStimulus("allones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        waitDone("allones", 16'hFFFF, 1'b1, 16'h0000, 1'b1, 4);

        $display("[TB] start_valid held while busy");
        applyStimulus("busyreq", 16'h00FF, 16'h0001, 1'b0, 1'b1);
        tbA = 16'hAAAA;
        tbB = 16'h1111;
        waitDone("busyreq", 16'h0100, 1'b0, 16'hFFFF, 1'b1, 4);
        applyStimulus("queued", 16'hAAAA, 16'h1111, 1'b0, 1'b0);
        waitDone("queued", 16'hBBBB, 1'b0, 16'h0100, 1'b0, 4);

        $display("[TB] async reset mid run");
        applyStimulus("abort", 16'h3333, 16'h4444, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("abort sum",   obsSum,   0);
        checkOutput("abort cout",  obsCout,  0);
        checkOutput("abort busy",  obsBusy,  0);
        checkOutput("abort ready", obsReady, 1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("abort no done", obsDone, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        applyStimulus("after abort", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        waitDone("after abort", 16'h1000, 1'b0, 16'h0000, 1'b0, 4);

        $display("[TB] WIDTH=8 build");
        sel = 1;
        @(negedge clk);
        applyStimulus("w8", 16'h0080, 16'h0080, 1'b0, 1'b0);
        waitDone("w8", 16'h0000, 1'b1, 16'h0000, 1'b0, 2);

        $display("[TB] WIDTH=4 build");
        sel = 2;
        @(negedge clk);
        applyStimulus("w4", 16'h0009, 16'h0008, 1'b1, 1'b0);
        waitDone("w4", 16'h0002, 1'b1, 16'h0000, 1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
